// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: round-robin arbiter that runs one DataBus transfer at a time
// as drive, load and turnaround phases on ControlSignals.
module bus_transfer_sequencer #(
  parameter int NREQ = 4,
  parameter int CSW  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*$clog2(CSW)-1:0] src_sel,
  input  logic [NREQ*$clog2(CSW)-1:0] dst_sel,
  output logic [NREQ-1:0]             ack,
  output logic                        err,
  output logic                        busy,
  output logic [2:0]                  grant_id,
  output logic [CSW-1:0]              ControlSignals
);
  localparam int SW = $clog2(CSW);
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, gid_n, win, idx;
  logic [SW-1:0] src, dst, src_n, dst_n;
  logic rej, rej_n, found, err_n, busy_n;
  logic [NREQ-1:0] ack_n;
  logic [CSW-1:0] cs_n;
  logic [7:0] req_x;
  logic [7:0][SW-1:0] src_x, dst_x;
  // widen to eight requesters so a 3-bit index selects exactly
  assign req_x = 8'(req);
  assign src_x = (8*SW)'(src_sel);
  assign dst_x = (8*SW)'(dst_sel);
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 3'((int'(ptr) + k) % NREQ);
      if (!found && req_x[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gid_n = grant_id;
    src_n = src;
    dst_n = dst;
    rej_n = rej;
    case (state)
      IDLE: if (found) begin
        gid_n = win;
        ptr_n = (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
        src_n = src_x[win];
        dst_n = dst_x[win];
        rej_n = src_x[win] == dst_x[win];
        state_n = rej_n ? DONE : DRIVE;
      end
      DRIVE: state_n = LOAD;
      LOAD: state_n = DONE;
      default: begin
        state_n = IDLE;
        rej_n = 1'b0;
      end
    endcase
    cs_n = (state_n == DRIVE) ? CSW'(1) << src_n :
           (state_n == LOAD) ? (CSW'(1) << src_n) | (CSW'(1) << dst_n) : '0;
    ack_n = (state_n == DONE) ? NREQ'(1) << gid_n : '0;
    err_n = (state_n == DONE) && rej_n;
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      src <= '0;
      dst <= '0;
      rej <= 1'b0;
      grant_id <= '0;
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      ControlSignals <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      src <= src_n;
      dst <= dst_n;
      rej <= rej_n;
      grant_id <= gid_n;
      ack <= ack_n;
      err <= err_n;
      busy <= busy_n;
      ControlSignals <= cs_n;
    end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed and randomized checks against a per-transfer
// script model of the sequencer's visible outputs.
module tb_bus_transfer_sequencer;
  localparam int NREQ = 4;
  localparam int CSW = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [4*NREQ-1:0] src_sel = '0;
  logic [4*NREQ-1:0] dst_sel = '0;
  logic [NREQ-1:0] ack;
  logic err, busy;
  logic [2:0] grant_id;
  logic [CSW-1:0] ControlSignals;
  typedef struct {
    logic [15:0] cs;
    logic [3:0] ack;
    logic err;
    logic busy;
    logic [2:0] gid;
  } exp_t;
  exp_t q[$];
  int m_ptr = 0;
  int m_gid = 0;
  int errors = 0;
  int checks = 0;
  bus_transfer_sequencer #(.NREQ(NREQ), .CSW(CSW)) dut (
    .clk(clk), .reset(reset), .req(req), .src_sel(src_sel), .dst_sel(dst_sel),
    .ack(ack), .err(err), .busy(busy), .grant_id(grant_id), .ControlSignals(ControlSignals)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(input int cs, input int a, input int e, input int b, input int g);
    exp_t r;
    r.cs = 16'(cs);
    r.ack = 4'(a);
    r.err = e[0];
    r.busy = b[0];
    r.gid = 3'(g);
    return r;
  endfunction
  // a grant queues the whole visible script of one transfer, ending with its IDLE cycle
  task automatic step();
    exp_t e;
    int w, s, d;
    @(posedge clk);
    if (q.size() == 0 && req != 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      s = int'(src_sel[4*w +: 4]);
      d = int'(dst_sel[4*w +: 4]);
      m_ptr = (w + 1) % NREQ;
      m_gid = w;
      if (s == d) q.push_back(mk(0, 1 << w, 1, 1, w));
      else begin
        q.push_back(mk(1 << s, 0, 0, 1, w));
        q.push_back(mk((1 << s) | (1 << d), 0, 0, 1, w));
        q.push_back(mk(0, 1 << w, 0, 1, w));
      end
      q.push_back(mk(0, 0, 0, 0, w));
    end
    e = (q.size() != 0) ? q.pop_front() : mk(0, 0, 0, 0, m_gid);
    #1;
    chk("cs", 32'(ControlSignals), 32'(e.cs));
    chk("ack", 32'(ack), 32'(e.ack));
    chk("err", 32'(err), 32'(e.err));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("grant_id", 32'(grant_id), 32'(e.gid));
    chk("excl", 32'($countones(ControlSignals) <= 2), 32'd1);
  endtask
  task automatic run(input int n);
    repeat (n) begin
      step();
      req = req & ~ack;
    end
  endtask
  initial begin
    #12;
    chk("rst_cs", 32'(ControlSignals), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    reset = 1'b1;
    src_sel[3:0] = 4'd3;
    dst_sel[3:0] = 4'd9;
    req = 4'b0001;
    run(5);
    src_sel[7:4] = 4'd5;
    dst_sel[7:4] = 4'd5;
    req = 4'b0010;
    run(3);
    src_sel[11:8] = 4'd2;
    dst_sel[11:8] = 4'd7;
    req = 4'b0100;
    step();
    src_sel = 16'($urandom);
    dst_sel = 16'($urandom);
    req = '0;
    run(4);
    src_sel = 16'h3210;
    dst_sel = 16'hBA98;
    req = 4'b1111;
    run(17);
    req = 4'b0101;
    run(9);
    src_sel[3:0] = 4'd3;
    dst_sel[3:0] = 4'd9;
    req = 4'b0001;
    step();
    step();
    chk("pre_rst_cs", 32'(ControlSignals), 32'h0208);
    #2 reset = 1'b0;
    #1;
    chk("async_cs", 32'(ControlSignals), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ack", 32'(ack), 32'd0);
    q.delete();
    m_ptr = 0;
    m_gid = 0;
    #1 reset = 1'b1;
    run(5);
    for (int c = 0; c < 1000; c++) begin
      step();
      req = req & ~ack;
      if (q.size() >= 2 && $urandom_range(0, 9) == 0) begin
        req[m_gid] = 1'b0;
        src_sel[4*m_gid +: 4] = 4'($urandom);
        dst_sel[4*m_gid +: 4] = 4'($urandom);
      end
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          src_sel[4*i +: 4] = 4'($urandom);
          dst_sel[4*i +: 4] = ($urandom_range(0, 7) == 0) ? src_sel[4*i +: 4] : 4'($urandom);
          req[i] = 1'b1;
        end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
